// File: rtl/irq_arbiter.sv
// Interrupt arbiter: latches source events as pending, picks a winner (fixed or rotating
// priority) and runs the request / acknowledge / service handshake with the core controller.
module irq_arbiter #(
  parameter int unsigned NUM_SRC     = 4,
  parameter bit          ROUND_ROBIN = 1'b0,
  parameter int unsigned CAUSE_BASE  = 16,
  localparam int unsigned ID_W       = $clog2(NUM_SRC)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] src_i,
  input  logic [NUM_SRC-1:0] enable_i,
  input  logic               global_ie_i,
  input  logic [31:0]        mtvec_i,
  input  logic               irq_ack_i,
  input  logic               mret_i,
  input  logic               flush_i,
  output logic               irq_req_o,
  output logic [ID_W-1:0]    irq_id_o,
  output logic [31:0]        irq_cause_o,
  output logic [31:0]        irq_vector_o,
  output logic               in_service_o,
  output logic [NUM_SRC-1:0] pending_o,
  output logic [31:0]        irq_count_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_e;

  state_e             state_q;
  logic [NUM_SRC-1:0] pending_q;
  logic [NUM_SRC-1:0] pending_d;
  logic [ID_W-1:0]    id_q;
  logic [ID_W-1:0]    rr_ptr_q;
  logic [ID_W-1:0]    rr_ptr_d;
  logic               req_q;
  logic               svc_q;
  logic [31:0]        count_q;

  logic [NUM_SRC-1:0] eligible_c;
  logic [NUM_SRC-1:0] clr_mask_c;
  logic               any_elig_c;
  logic               ack_take_c;
  logic [ID_W-1:0]    winner_c;
  logic [31:0]        vec_base_c;
  logic [31:0]        vec_off_c;

  assign eligible_c = pending_q & enable_i;
  assign any_elig_c = |eligible_c;
  assign ack_take_c = (state_q == REQ) && irq_ack_i;

  // A new event on the acknowledged source survives the clear.
  assign clr_mask_c = ack_take_c ? (NUM_SRC'(1) << id_q) : '0;
  assign pending_d  = (pending_q & ~clr_mask_c) | src_i;
  assign rr_ptr_d   = (id_q == ID_W'(NUM_SRC - 1)) ? '0 : id_q + 1'b1;

  // Winner search starts at rr_ptr (rotating) or at index 0 (fixed), wrapping around.
  always_comb begin
    int unsigned start;
    int unsigned idx;
    logic        found;
    start    = ROUND_ROBIN ? 32'(rr_ptr_q) : 32'd0;
    idx      = 0;
    found    = 1'b0;
    winner_c = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      idx = start + k;
      if (idx >= NUM_SRC) begin
        idx = idx - NUM_SRC;
      end
      if (!found && eligible_c[ID_W'(idx)]) begin
        found    = 1'b1;
        winner_c = ID_W'(idx);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pending_q <= '0;
      id_q      <= '0;
      rr_ptr_q  <= '0;
      req_q     <= 1'b0;
      svc_q     <= 1'b0;
      count_q   <= '0;
    end else if (flush_i) begin
      state_q   <= IDLE;
      pending_q <= '0;
      req_q     <= 1'b0;
      svc_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      case (state_q)
        IDLE: begin
          if (global_ie_i && any_elig_c) begin
            id_q    <= winner_c;
            req_q   <= 1'b1;
            state_q <= REQ;
          end
        end
        REQ: begin
          if (irq_ack_i) begin
            count_q  <= count_q + 32'd1;
            rr_ptr_q <= rr_ptr_d;
            req_q    <= 1'b0;
            svc_q    <= 1'b1;
            state_q  <= SERVICE;
          end else if (!global_ie_i || !eligible_c[id_q]) begin
            req_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        SERVICE: begin
          if (mret_i) begin
            svc_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          req_q   <= 1'b0;
          svc_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Vectored mode only for mode 1; modes 2 and 3 fall back to direct.
  assign vec_base_c   = {mtvec_i[31:2], 2'b00};
  assign vec_off_c    = (CAUSE_BASE + 32'(id_q)) << 2;
  assign irq_vector_o = (mtvec_i[1:0] == 2'b01) ? vec_base_c + vec_off_c : vec_base_c;
  assign irq_cause_o  = {1'b1, 31'(CAUSE_BASE + 32'(id_q))};

  assign irq_req_o    = req_q;
  assign irq_id_o     = id_q;
  assign in_service_o = svc_q;
  assign pending_o    = pending_q;
  assign irq_count_o  = count_q;

endmodule

// File: tb/tb_irq_arbiter.sv
// Bench for irq_arbiter: a fixed-priority and a rotating instance share stimulus and are
// compared every cycle against a behavioural model, plus directed literal checks.
module tb_irq_arbiter;

  localparam int N = 4;

  logic        clk;
  logic        reset;
  logic [3:0]  src;
  logic [3:0]  en;
  logic        gie;
  logic        flush;
  logic [31:0] mtvec;
  logic        ack  [2];
  logic        mret [2];

  logic        req_o   [2];
  logic        insvc_o [2];
  logic [1:0]  id_o    [2];
  logic [31:0] cause_o [2];
  logic [31:0] vec_o   [2];
  logic [31:0] cnt_o   [2];
  logic [3:0]  pend_o  [2];

  int errors = 0;
  int checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  irq_arbiter #(.NUM_SRC(4), .ROUND_ROBIN(1'b0), .CAUSE_BASE(16)) u_fix (
    .clk(clk), .reset(reset), .src_i(src), .enable_i(en), .global_ie_i(gie),
    .mtvec_i(mtvec), .irq_ack_i(ack[0]), .mret_i(mret[0]), .flush_i(flush),
    .irq_req_o(req_o[0]), .irq_id_o(id_o[0]), .irq_cause_o(cause_o[0]),
    .irq_vector_o(vec_o[0]), .in_service_o(insvc_o[0]), .pending_o(pend_o[0]),
    .irq_count_o(cnt_o[0])
  );

  irq_arbiter #(.NUM_SRC(4), .ROUND_ROBIN(1'b1), .CAUSE_BASE(16)) u_rr (
    .clk(clk), .reset(reset), .src_i(src), .enable_i(en), .global_ie_i(gie),
    .mtvec_i(mtvec), .irq_ack_i(ack[1]), .mret_i(mret[1]), .flush_i(flush),
    .irq_req_o(req_o[1]), .irq_id_o(id_o[1]), .irq_cause_o(cause_o[1]),
    .irq_vector_o(vec_o[1]), .in_service_o(insvc_o[1]), .pending_o(pend_o[1]),
    .irq_count_o(cnt_o[1])
  );

  // Behavioural model: mst 0=idle, 1=requesting, 2=in service.
  int          mst  [2];
  int          mid  [2];
  int          mrr  [2];
  logic [3:0]  mpend[2];
  logic [31:0] mcnt [2];

  function automatic int pick(input int k, input logic [3:0] el);
    int start;
    int i;
    start = (k == 1) ? mrr[k] : 0;
    for (int j = 0; j < N; j++) begin
      i = (start + j) % N;
      if (el[i]) return i;
    end
    return 0;
  endfunction

  always @(posedge clk or posedge reset) begin : model
    logic [3:0] el;
    logic [3:0] np;
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        mst[k]   <= 0;
        mid[k]   <= 0;
        mrr[k]   <= 0;
        mpend[k] <= '0;
        mcnt[k]  <= '0;
      end else if (flush) begin
        mst[k]   <= 0;
        mpend[k] <= '0;
      end else begin
        el = mpend[k] & en;
        np = mpend[k] | src;
        if (mst[k] == 0) begin
          if (gie && el != 4'd0) begin
            mid[k] <= pick(k, el);
            mst[k] <= 1;
          end
        end else if (mst[k] == 1) begin
          if (ack[k]) begin
            np[mid[k]] = src[mid[k]];
            mcnt[k]    <= mcnt[k] + 32'd1;
            mrr[k]     <= (mid[k] + 1) % N;
            mst[k]     <= 2;
          end else if (!gie || !el[mid[k]]) begin
            mst[k] <= 0;
          end
        end else if (mret[k]) begin
          mst[k] <= 0;
        end
        mpend[k] <= np;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic [31:0] base;
    for (int k = 0; k < 2; k++) begin
      base = mtvec & 32'hFFFF_FFFC;
      chk($sformatf("inst%0d req", k), 32'(req_o[k]), 32'(mst[k] == 1));
      chk($sformatf("inst%0d in_service", k), 32'(insvc_o[k]), 32'(mst[k] == 2));
      chk($sformatf("inst%0d id", k), 32'(id_o[k]), 32'(mid[k]));
      chk($sformatf("inst%0d pending", k), 32'(pend_o[k]), 32'(mpend[k]));
      chk($sformatf("inst%0d count", k), cnt_o[k], mcnt[k]);
      chk($sformatf("inst%0d cause", k), cause_o[k], 32'h8000_0000 + 32'(16 + mid[k]));
      chk($sformatf("inst%0d vector", k), vec_o[k],
          (mtvec[1:0] == 2'b01) ? base + 32'(4 * (16 + mid[k])) : base);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b1; src = '0; en = 4'hF; gie = 1'b1; flush = 1'b0; mtvec = 32'h0000_1001;
    ack[0] = 1'b0; ack[1] = 1'b0; mret[0] = 1'b0; mret[1] = 1'b0;
    step(); step();
    chk("reset req", 32'(req_o[0]), 32'd0);
    chk("reset id", 32'(id_o[0]), 32'd0);
    chk("reset count", cnt_o[0], 32'd0);
    reset = 1'b0;
    step();

    // Fixed priority, latency and cause/vector literals.
    src = 4'b0110; step(); src = '0;
    chk("fp latency req low", 32'(req_o[0]), 32'd0);
    step();
    chk("fp req", 32'(req_o[0]), 32'd1);
    chk("fp id", 32'(id_o[0]), 32'd1);
    chk("fp cause", cause_o[0], 32'h8000_0011);
    chk("fp vector id1", vec_o[0], 32'h0000_1044);
    ack[0] = 1'b1; step(); ack[0] = 1'b0;
    chk("fp in_service", 32'(insvc_o[0]), 32'd1);
    chk("fp pending after ack", 32'(pend_o[0]), 32'h4);
    mret[0] = 1'b1; step(); mret[0] = 1'b0;
    step();
    chk("fp second id", 32'(id_o[0]), 32'd2);
    chk("vectored id2", vec_o[0], 32'h0000_1048);
    mtvec = 32'h0000_1000; #1;
    chk("direct vector", vec_o[0], 32'h0000_1000);
    ack[0] = 1'b1; step(); ack[0] = 1'b0;
    chk("fp count", cnt_o[0], 32'd2);
    flush = 1'b1; step(); flush = 1'b0;

    // Rotating priority: order 0,1,2,3,0.
    src = 4'hF; step(); src = '0; step();
    for (int g = 0; g < 5; g++) begin
      chk($sformatf("rr grant%0d req", g), 32'(req_o[1]), 32'd1);
      chk($sformatf("rr grant%0d id", g), 32'(id_o[1]), 32'(g % 4));
      ack[1] = 1'b1; step(); ack[1] = 1'b0;
      mret[1] = 1'b1; src = 4'hF; step(); mret[1] = 1'b0; src = '0;
      step();
    end
    chk("rr count", cnt_o[1], 32'd5);
    flush = 1'b1; step(); flush = 1'b0;

    // Withdraw, ack/withdraw collision, set-wins on ack cycle.
    src = 4'b0001; step(); src = '0; step();
    chk("wd req", 32'(req_o[0]), 32'd1);
    en = 4'b1110; step();
    chk("wd withdrawn", 32'(req_o[0]), 32'd0);
    chk("wd pending kept", 32'(pend_o[0]), 32'h1);
    en = 4'hF; step();
    chk("wd re-request", 32'(req_o[0]), 32'd1);
    en = 4'b1110; ack[0] = 1'b1; src = 4'b0001; step();
    ack[0] = 1'b0; en = 4'hF; src = '0;
    chk("collision service", 32'(insvc_o[0]), 32'd1);
    chk("set wins", 32'(pend_o[0]), 32'h1);
    chk("collision count", cnt_o[0], 32'd3);
    src = 4'b0110; step(); src = '0;
    chk("three pending", 32'(pend_o[0]), 32'h7);
    flush = 1'b1; step(); flush = 1'b0;
    chk("flush pending", 32'(pend_o[0]), 32'd0);
    chk("flush service", 32'(insvc_o[0]), 32'd0);
    chk("flush count kept", cnt_o[0], 32'd3);

    // Asynchronous reset in the middle of a request.
    src = 4'b0001; step(); src = '0; step();
    chk("pre-reset req", 32'(req_o[0]), 32'd1);
    #1 reset = 1'b1; #1;
    chk("async reset req", 32'(req_o[0]), 32'd0);
    chk("async reset pending", 32'(pend_o[0]), 32'd0);
    chk("async reset count", cnt_o[0], 32'd0);
    step(); reset = 1'b0;

    // Randomized traffic, checked every cycle by the compare process.
    for (int c = 0; c < 3000; c++) begin
      step();
      src     = 4'($urandom_range(0, 7) == 0) | (4'($urandom_range(0, 7) == 0) << 1)
              | (4'($urandom_range(0, 7) == 0) << 2) | (4'($urandom_range(0, 7) == 0) << 3);
      en      = ($urandom_range(0, 3) == 0) ? 4'($urandom()) : 4'hF;
      gie     = ($urandom_range(0, 7) != 0);
      flush   = ($urandom_range(0, 63) == 0);
      mtvec   = $urandom();
      ack[0]  = 1'($urandom_range(0, 1));
      ack[1]  = 1'($urandom_range(0, 1));
      mret[0] = ($urandom_range(0, 2) == 0);
      mret[1] = ($urandom_range(0, 2) == 0);
    end
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/irq_arbiter.md
Name: irq_arbiter

Overview:
- Collects N interrupt sources, latches them as pending, and selects one winner.
- Sequences the interrupt handshake with core_controller_fsm: request, acknowledge on handler entry, service, then release on MRET.
- Supplies the cause code and handler vector (direct or vectored mtvec) to the core and CSR path.
- Sits between the peripheral/timer interrupt lines and the core controller.

Parameters:
NUM_SRC, 4, number of interrupt sources (2..16)
ROUND_ROBIN, 0, 0 = fixed priority (index 0 highest); 1 = rotating priority
CAUSE_BASE, 16, cause code of source 0; source i reports CAUSE_BASE+i

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous active-high reset
src_i  input  NUM_SRC  per-source interrupt event pulses (1 = event this cycle)
enable_i  input  NUM_SRC  per-source enable mask (mie-style)
global_ie_i  input  1  global interrupt enable (mstatus.MIE)
mtvec_i  input  32  trap vector CSR; [1:0]=mode, [31:2]=base
irq_ack_i  input  1  core has entered handler (ready_for_irq_handler while in PARTIAL_IRQ)
mret_i  input  1  MRET retired; ends service
flush_i  input  1  full-flush request (reset_request)
irq_req_o  output  1  interrupt request to core
irq_id_o  output  $clog2(NUM_SRC)  id of requested / in-service source
irq_cause_o  output  32  {1'b1, CAUSE_BASE+irq_id_o}, zero-extended to 31 bits
irq_vector_o  output  32  handler address
in_service_o  output  1  a handler is running
pending_o  output  NUM_SRC  pending register
irq_count_o  output  32  number of acknowledged interrupts

Behaviour:
- Reset (async, immediate):
  - state=IDLE; pending=0; rr_ptr=0; irq_count_o=0.
  - irq_req_o=0, in_service_o=0, irq_id_o=0.
- Pending register:
  - pending[i] is set when src_i[i]=1.
  - pending[i] is cleared on the cycle irq_ack_i is accepted for id i.
  - Set and clear of the same bit in one cycle: set wins, so the new event is kept.
  - Pending bits latch regardless of enable_i, global_ie_i and state.
- Eligibility: eligible = pending & enable_i. The winner is computed combinationally from eligible.
  - ROUND_ROBIN=0: lowest set index wins.
  - ROUND_ROBIN=1: first set index at or after rr_ptr, searching with wrap-around modulo NUM_SRC.
- States: IDLE, REQ, SERVICE.
  - IDLE: if global_ie_i and any eligible bit is set, register the winner into irq_id_o and go to REQ. irq_req_o rises the next cycle.
  - REQ: irq_req_o=1 and irq_id_o is held stable.
    - If irq_ack_i: clear pending[id], increment irq_count_o (wraps at 2^32), set rr_ptr=(id+1) mod NUM_SRC, go to SERVICE.
    - Else if global_ie_i=0 or eligible[id]=0: withdraw and return to IDLE.
    - irq_ack_i in the same cycle as a withdraw condition: the ack wins.
  - SERVICE: in_service_o=1, irq_req_o=0, irq_id_o held. No nesting. On mret_i go to IDLE.
- Latency:
  - Event to irq_req_o: 2 cycles (pending latch, then IDLE->REQ).
  - mret_i to the next irq_req_o: 2 cycles minimum.
- flush_i: in any state, next cycle state=IDLE, pending=0, irq_req_o=0, in_service_o=0. irq_count_o and rr_ptr are kept.
  - flush_i takes priority over ack, mret and src_i in the same cycle.
- Ignored inputs: irq_ack_i outside REQ and mret_i outside SERVICE have no effect.
- Outputs:
  - irq_cause_o is valid whenever irq_req_o or in_service_o is 1; otherwise it still reflects irq_id_o.
  - irq_vector_o = {mtvec_i[31:2],2'b00} when mtvec_i[1:0]=0.
  - irq_vector_o = {mtvec_i[31:2],2'b00} + 4*(CAUSE_BASE+irq_id_o) when mtvec_i[1:0]=1.
  - Modes 2 and 3 are treated as mode 0.

Test Plan:
- Fixed priority: src_i=4'b0110 pulsed, enable_i=4'hF, global_ie_i=1 -> irq_req_o at cycle+2 with irq_id_o=1 and irq_cause_o=32'h80000011. Ack then MRET -> second request with irq_id_o=2; irq_count_o=2.
- Round robin (ROUND_ROBIN=1): all four sources pending repeatedly, ack+MRET each time -> grant order 0,1,2,3,0; rr_ptr wraps from 3 to 0.
- Vectored mode: mtvec_i=32'h00001001, id 2 -> irq_vector_o=32'h00001048. With mtvec_i=32'h00001000 -> irq_vector_o=32'h00001000.
- Withdraw and collision:
  - In REQ, drop enable_i[id] without ack -> irq_req_o=0 next cycle, pending bit retained.
  - Repeat with ack in the same cycle as the drop -> SERVICE entered.
  - src_i[id] pulses on the ack cycle -> pending[id] stays 1.
- Flush and reset: flush_i asserted in SERVICE with 3 bits pending -> next cycle IDLE, pending_o=0, irq_count_o unchanged. Async reset mid-REQ -> all outputs 0 without a clock edge.
